// File: rtl/riscv_rf_writeback.sv
// Register-file writeback arbiter: direct ALU port A, mult/LSU port B with an
// in-order LSU write buffer, and per-register pending-write (busy) tracking.
module riscv_rf_writeback #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]                ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]                ex_wdata_i,
  input  logic                                 mult_valid_i,
  input  logic [ADDR_WIDTH-1:0]                mult_waddr_i,
  input  logic [DATA_WIDTH-1:0]                mult_wdata_i,
  input  logic                                 lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]                lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]                lsu_wdata_i,
  output logic                                 lsu_ready_o,
  input  logic                                 claim_i,
  input  logic [ADDR_WIDTH-1:0]                claim_addr_i,
  output logic [(2**ADDR_WIDTH)-1:0]           busy_o,
  output logic                                 we_a_o,
  output logic [ADDR_WIDTH-1:0]                waddr_a_o,
  output logic [DATA_WIDTH-1:0]                wdata_a_o,
  output logic                                 we_b_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;

  logic                  fifo_empty, lsu_accept, push, pop;
  logic                  b_sel, a_we, b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic [NREG-1:0]       busy_next;

  // Writes to integer x0 are dropped; the FP bank's f0 is a real register.
  function automatic logic is_x0(input logic [ADDR_WIDTH-1:0] a);
    return a == '0;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  assign fifo_empty  = (fifo_count_o == '0);
  assign lsu_ready_o = (fifo_count_o < CW'(FIFO_DEPTH));
  assign lsu_accept  = lsu_valid_i && lsu_ready_o;
  assign a_we        = ex_valid_i && !is_x0(ex_waddr_i);
  assign b_we        = b_sel && !is_x0(b_addr);

  // Port B source select: mult, then buffered loads, then load bypass.
  always_comb begin
    b_sel  = 1'b0;
    b_addr = waddr_b_o;
    b_data = wdata_b_o;
    push   = 1'b0;
    pop    = 1'b0;
    if (mult_valid_i) begin
      b_sel  = 1'b1;
      b_addr = mult_waddr_i;
      b_data = mult_wdata_i;
      push   = lsu_accept;
    end else if (!fifo_empty) begin
      b_sel  = 1'b1;
      b_addr = fifo_addr[rd_ptr];
      b_data = fifo_data[rd_ptr];
      pop    = 1'b1;
      push   = lsu_accept;
    end else if (lsu_accept) begin
      b_sel  = 1'b1;
      b_addr = lsu_waddr_i;
      b_data = lsu_wdata_i;
    end
  end

  // Busy scoreboard: a claim on the same edge as the retiring write wins.
  always_comb begin
    busy_next = '0;
    for (int unsigned k = 1; k < NREG; k++) begin
      busy_next[k] = (claim_i && (claim_addr_i == ADDR_WIDTH'(k))) ||
                     (busy_o[k] &&
                      !(a_we && (ex_waddr_i == ADDR_WIDTH'(k))) &&
                      !(b_we && (b_addr == ADDR_WIDTH'(k))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_a_o       <= 1'b0;
      waddr_a_o    <= '0;
      wdata_a_o    <= '0;
      we_b_o       <= 1'b0;
      waddr_b_o    <= '0;
      wdata_b_o    <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count_o <= '0;
      busy_o       <= '0;
    end else begin
      we_a_o    <= a_we;
      waddr_a_o <= ex_waddr_i;
      wdata_a_o <= ex_wdata_i;
      we_b_o    <= b_we;
      waddr_b_o <= b_addr;
      wdata_b_o <= b_data;
      busy_o    <= busy_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count_o <= CW'(fifo_count_o + 1'b1);
      else if (pop && !push) fifo_count_o <= CW'(fifo_count_o - 1'b1);
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lsu_waddr_i;
      fifo_data[wr_ptr] <= lsu_wdata_i;
    end
  end

endmodule

// File: tb/tb_riscv_rf_writeback.sv
// Directed bench for riscv_rf_writeback: port A latency, load bypass/buffering
// behind mult traffic, x0 suppression, busy scoreboard and mid-run reset.
module tb_riscv_rf_writeback;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid_i, mult_valid_i, lsu_valid_i, claim_i;
  logic [AW-1:0] ex_waddr_i, mult_waddr_i, lsu_waddr_i, claim_addr_i;
  logic [DW-1:0] ex_wdata_i, mult_wdata_i, lsu_wdata_i;
  logic          lsu_ready_o, we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  logic [63:0]   busy_o;
  logic [1:0]    fifo_count_o;

  int checks = 0;
  int errors = 0;

  bit       exp_rdy [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
  bit       exp_web [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int       exp_ab  [8] = '{10, 11, 12, 13, 20, 21, 22, 0};
  int       exp_db  [8] = '{'h100, 'h101, 'h102, 'h103, 'h200, 'h201, 'h202, 0};
  int       exp_cnt [8] = '{1, 2, 2, 2, 1, 1, 0, 0};

  riscv_rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .mult_valid_i(mult_valid_i), .mult_waddr_i(mult_waddr_i), .mult_wdata_i(mult_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(lsu_ready_o), .claim_i(claim_i), .claim_addr_i(claim_addr_i),
    .busy_o(busy_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_i = 0; ex_waddr_i = '0; ex_wdata_i = '0;
    mult_valid_i = 0; mult_waddr_i = '0; mult_wdata_i = '0;
    lsu_valid_i = 0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    claim_i = 0; claim_addr_i = '0;
  endtask

  task automatic test_reset();
    checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL reset_we: we_a=%b we_b=%b expected 0 0", we_a_o, we_b_o); end
    checks++; if (waddr_a_o !== '0 || wdata_a_o !== '0 || waddr_b_o !== '0 || wdata_b_o !== '0) begin errors++;
      $display("FAIL reset_addr_data: a=%h/%h b=%h/%h expected all 0", waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o); end
    checks++; if (fifo_count_o !== 2'd0 || lsu_ready_o !== 1'b1) begin errors++;
      $display("FAIL reset_fifo: count=%0d ready=%b expected 0 1", fifo_count_o, lsu_ready_o); end
    checks++; if (busy_o !== 64'd0) begin errors++;
      $display("FAIL reset_busy: busy=%h expected 0", busy_o); end
  endtask

  task automatic test_port_a();
    ex_valid_i = 1; ex_waddr_i = 6'd5; ex_wdata_i = 32'hDEADBEEF;
    step();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd5 || wdata_a_o !== 32'hDEADBEEF) begin errors++;
      $display("FAIL port_a_write: we=%b addr=%0d data=%h expected 1 5 deadbeef", we_a_o, waddr_a_o, wdata_a_o); end
    ex_valid_i = 0;
    step();
    checks++; if (we_a_o !== 1'b0) begin errors++;
      $display("FAIL port_a_one_cycle: we=%b expected 0", we_a_o); end
    ex_valid_i = 1; ex_waddr_i = 6'd0; ex_wdata_i = 32'h11111111;
    step();
    checks++; if (we_a_o !== 1'b0) begin errors++;
      $display("FAIL port_a_x0: we=%b expected 0", we_a_o); end
    ex_waddr_i = 6'd32; ex_wdata_i = 32'h22222222;
    step();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd32 || wdata_a_o !== 32'h22222222) begin errors++;
      $display("FAIL port_a_f0: we=%b addr=%0d data=%h expected 1 32 22222222", we_a_o, waddr_a_o, wdata_a_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_bypass();
    lsu_valid_i = 1; lsu_waddr_i = 6'd7; lsu_wdata_i = 32'h1234;
    step();
    checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 6'd7 || wdata_b_o !== 32'h1234) begin errors++;
      $display("FAIL bypass_write: we=%b addr=%0d data=%h expected 1 7 1234", we_b_o, waddr_b_o, wdata_b_o); end
    checks++; if (fifo_count_o !== 2'd0) begin errors++;
      $display("FAIL bypass_count: count=%0d expected 0", fifo_count_o); end
    lsu_valid_i = 0;
    step();
    checks++; if (we_b_o !== 1'b0) begin errors++;
      $display("FAIL bypass_idle: we_b=%b expected 0", we_b_o); end
    mult_valid_i = 1; mult_waddr_i = 6'd0; mult_wdata_i = 32'h5;
    step();
    checks++; if (we_b_o !== 1'b0) begin errors++;
      $display("FAIL port_b_x0: we_b=%b expected 0", we_b_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_mult_starve();
    int li = 0;
    bit acc;
    for (int c = 0; c < 8; c++) begin
      mult_valid_i = (c < 4);
      mult_waddr_i = AW'(10 + c);
      mult_wdata_i = DW'(32'h100 + c);
      lsu_valid_i  = (li < 3);
      lsu_waddr_i  = AW'(20 + li);
      lsu_wdata_i  = DW'(32'h200 + li);
      checks++; if (lsu_ready_o !== exp_rdy[c]) begin errors++;
        $display("FAIL starve_ready[%0d]: ready=%b expected %b", c, lsu_ready_o, exp_rdy[c]); end
      acc = lsu_valid_i && lsu_ready_o;
      step();
      if (acc) li++;
      checks++; if (we_b_o !== exp_web[c] || (exp_web[c] &&
                    (waddr_b_o !== AW'(exp_ab[c]) || wdata_b_o !== DW'(exp_db[c])))) begin errors++;
        $display("FAIL starve_port_b[%0d]: we=%b addr=%0d data=%h expected %b %0d %h",
                 c, we_b_o, waddr_b_o, wdata_b_o, exp_web[c], exp_ab[c], exp_db[c]); end
      checks++; if (fifo_count_o !== 2'(exp_cnt[c])) begin errors++;
        $display("FAIL starve_count[%0d]: count=%0d expected %0d", c, fifo_count_o, exp_cnt[c]); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_busy();
    claim_i = 1; claim_addr_i = 6'd9;
    step();
    checks++; if (busy_o[9] !== 1'b1) begin errors++;
      $display("FAIL busy_set: busy[9]=%b expected 1", busy_o[9]); end
    claim_i = 0; ex_valid_i = 1; ex_waddr_i = 6'd9; ex_wdata_i = 32'h9;
    step();
    ex_valid_i = 0;
    step();
    checks++; if (busy_o[9] !== 1'b0) begin errors++;
      $display("FAIL busy_clear: busy[9]=%b expected 0", busy_o[9]); end
    claim_i = 1; claim_addr_i = 6'd9;
    step();
    claim_i = 1; claim_addr_i = 6'd9; ex_valid_i = 1; ex_waddr_i = 6'd9;
    step();
    claim_i = 0; ex_valid_i = 0;
    step();
    checks++; if (busy_o[9] !== 1'b1) begin errors++;
      $display("FAIL busy_set_wins: busy[9]=%b expected 1", busy_o[9]); end
    lsu_valid_i = 1; lsu_waddr_i = 6'd9; lsu_wdata_i = 32'h99;
    step();
    lsu_valid_i = 0;
    checks++; if (busy_o[9] !== 1'b0 || we_b_o !== 1'b1) begin errors++;
      $display("FAIL busy_clear_port_b: busy[9]=%b we_b=%b expected 0 1", busy_o[9], we_b_o); end
    claim_i = 1; claim_addr_i = 6'd0;
    step();
    claim_i = 1; claim_addr_i = 6'd12;
    step();
    checks++; if (busy_o !== (64'd1 << 12)) begin errors++;
      $display("FAIL busy_x0_claim: busy=%h expected %h", busy_o, 64'd1 << 12); end
    claim_i = 0;
    ex_valid_i = 1; ex_waddr_i = 6'd12; ex_wdata_i = 32'hAAAA;
    mult_valid_i = 1; mult_waddr_i = 6'd12; mult_wdata_i = 32'hBBBB;
    step();
    idle_inputs();
    checks++; if (we_a_o !== 1'b1 || we_b_o !== 1'b1 || wdata_a_o !== 32'hAAAA ||
                  wdata_b_o !== 32'hBBBB || waddr_a_o !== 6'd12 || waddr_b_o !== 6'd12) begin errors++;
      $display("FAIL same_addr_ab: a=%b/%0d/%h b=%b/%0d/%h expected 1/12/aaaa 1/12/bbbb",
               we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o); end
    checks++; if (busy_o !== 64'd0) begin errors++;
      $display("FAIL same_addr_busy: busy=%h expected 0", busy_o); end
    step();
  endtask

  task automatic test_reset_mid();
    claim_i = 1; claim_addr_i = 6'd15;
    mult_valid_i = 1; mult_waddr_i = 6'd3; mult_wdata_i = 32'h3;
    lsu_valid_i = 1; lsu_waddr_i = 6'd30; lsu_wdata_i = 32'h30;
    step();
    claim_i = 0; lsu_waddr_i = 6'd31; lsu_wdata_i = 32'h31;
    step();
    checks++; if (fifo_count_o !== 2'd2 || busy_o[15] !== 1'b1) begin errors++;
      $display("FAIL pre_reset_fill: count=%0d busy[15]=%b expected 2 1", fifo_count_o, busy_o[15]); end
    #2 rst = 1;
    #1;
    checks++; if (fifo_count_o !== 2'd0 || busy_o !== 64'd0 || lsu_ready_o !== 1'b1 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL async_reset: count=%0d busy=%h ready=%b we_b=%b expected 0 0 1 0",
               fifo_count_o, busy_o, lsu_ready_o, we_b_o); end
    idle_inputs();
    step();
    rst = 0;
    step();
    checks++; if (we_b_o !== 1'b0 || fifo_count_o !== 2'd0) begin errors++;
      $display("FAIL post_reset_b1: we_b=%b count=%0d expected 0 0", we_b_o, fifo_count_o); end
    step();
    checks++; if (we_b_o !== 1'b0 || busy_o !== 64'd0) begin errors++;
      $display("FAIL post_reset_b2: we_b=%b busy=%h expected 0 0", we_b_o, busy_o); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) step();
    test_reset();
    rst = 0;
    step();
    test_port_a();
    test_bypass();
    test_mult_starve();
    test_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
